// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state encoding and line-polarity helper for decoder blocks
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BLANK = 2'd2
    } decoder_state_e;

    // Level of one output line: opt=1 gives active-high one-hot, opt=0 active-low one-cold.
    function automatic logic line_level(input logic hit, input logic opt);
        return opt ? hit : ~hit;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// rtl/decoder_onehot.sv - combinational select-to-lines decoder with polarity control
module decoder_onehot #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]    sel,
    input  logic                active,
    input  logic                opt,
    output logic [2**SEL_W-1:0] y
);
    import decoder_pkg::*;

    for (genvar i = 0; i < 2**SEL_W; i++) begin : g_line
        assign y[i] = line_level(active && (sel == SEL_W'(i)), opt);
    end

endmodule

// File: rtl/decoder_scan_nx.sv
// rtl/decoder_scan_nx.sv - manual/auto-scan channel decoder with dwell and blanking
module decoder_scan_nx #(
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 8,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_mode,
    input  logic                i_opt,
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_load,
    output logic [2**SEL_W-1:0] o_y,
    output logic [SEL_W-1:0]    o_idx,
    output logic                o_wrap,
    output logic                o_err
);
    import decoder_pkg::*;

    localparam int CNT_MAX    = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;

    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_LAST);
    localparam logic [SEL_W:0]   CH_LIMIT  = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CH - 1);

    decoder_state_e     state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SEL_W-1:0]   idx_n;
    logic               mode_q;
    logic               wrap_n, err_n;
    logic               adv_wrap;
    logic [SEL_W-1:0]   adv_idx;
    logic               drive_n;
    logic [2**SEL_W-1:0] y_n;

    assign adv_wrap = (o_idx == LAST_CH);
    assign adv_idx  = adv_wrap ? '0 : o_idx + 1'b1;

    always_comb begin
        state_n = state;
        idx_n   = o_idx;
        cnt_n   = cnt;
        wrap_n  = 1'b0;
        err_n   = 1'b0;
        if (!i_en) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (!i_mode) begin
            cnt_n = '0;
            // Leaving scan mode parks the block; the load is only honoured once settled.
            if (state == ST_BLANK || (state == ST_DRIVE && mode_q)) begin
                state_n = ST_IDLE;
            end else if (i_load) begin
                if ({1'b0, i_sel} < CH_LIMIT) begin
                    state_n = ST_DRIVE;
                    idx_n   = i_sel;
                end else begin
                    err_n = 1'b1;
                end
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_DRIVE;
                    cnt_n   = '0;
                end
                ST_DRIVE: begin
                    // A drive inherited from manual mode restarts its dwell from zero.
                    if (!mode_q) begin
                        cnt_n = '0;
                    end else if (cnt == DWELL_END) begin
                        cnt_n = '0;
                        if (BLANK == 0) begin
                            idx_n  = adv_idx;
                            wrap_n = adv_wrap;
                        end else begin
                            state_n = ST_BLANK;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (cnt == BLANK_END) begin
                        state_n = ST_DRIVE;
                        cnt_n   = '0;
                        idx_n   = adv_idx;
                        wrap_n  = adv_wrap;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign drive_n = (state_n == ST_DRIVE);

    decoder_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .sel    (idx_n),
        .active (drive_n),
        .opt    (i_opt),
        .y      (y_n)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            o_idx  <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
            o_y    <= '1;
            o_wrap <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            state  <= state_n;
            o_idx  <= idx_n;
            cnt    <= cnt_n;
            mode_q <= i_mode;
            o_y    <= y_n;
            o_wrap <= wrap_n;
            o_err  <= err_n;
        end
    end

endmodule

// File: tb/tb_decoder_scan_nx.sv
// tb/tb_decoder_scan_nx.sv - scoreboard bench for decoder_scan_nx
module tb_decoder_scan_nx;

    localparam int SEL_W  = 3;
    localparam int NUM_CH = 6;
    localparam int DWELL  = 4;
    localparam int BLANK  = 1;

    logic       i_clk = 1'b0;
    logic       i_rst_n, i_en, i_mode, i_opt, i_load;
    logic [2:0] i_sel;
    logic [7:0] o_y;
    logic [2:0] o_idx;
    logic       o_wrap, o_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
        logic       err;
    } exp_t;

    exp_t sb[$];

    // Reference model: a channel slot is DWELL driven cycles followed by BLANK dark ones.
    bit m_run;
    int m_idx, m_pos;
    bit m_last;

    decoder_scan_nx #(
        .SEL_W(SEL_W), .NUM_CH(NUM_CH), .DWELL(DWELL), .BLANK(BLANK)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_mode(i_mode),
        .i_opt(i_opt), .i_sel(i_sel), .i_load(i_load),
        .o_y(o_y), .o_idx(o_idx), .o_wrap(o_wrap), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        logic [7:0] inact;
        bit active;
        e.wrap = 1'b0;
        e.err  = 1'b0;
        if (!i_rst_n) begin
            m_run = 0; m_idx = 0; m_pos = 0; m_last = 0;
            e.y = 8'hFF;
            e.idx = 3'd0;
            sb.push_back(e);
            return;
        end
        if (!i_en) begin
            m_run = 0;
            m_pos = 0;
        end else if (!i_mode) begin
            if (m_run && m_last) begin
                m_run = 0;
            end else if (i_load) begin
                if (int'(i_sel) < NUM_CH) begin
                    m_run = 1; m_idx = int'(i_sel); m_pos = 0;
                end else begin
                    e.err = 1'b1;
                end
            end
        end else begin
            if (!m_run || !m_last) begin
                m_run = 1;
                m_pos = 0;
            end else begin
                m_pos++;
                if (m_pos == DWELL + BLANK) begin
                    m_pos  = 0;
                    m_idx  = (m_idx + 1) % NUM_CH;
                    e.wrap = (m_idx == 0);
                end
            end
        end
        m_last = i_mode;
        inact  = i_opt ? 8'h00 : 8'hFF;
        active = m_run && (!i_mode || m_pos < DWELL);
        e.y    = active ? (inact ^ (8'h01 << m_idx)) : inact;
        e.idx  = 3'(m_idx);
        sb.push_back(e);
    endtask

    task automatic cycle();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_y",    32'(o_y),    32'(e.y));
                check("sb_idx",  32'(o_idx),  32'(e.idx));
                check("sb_wrap", 32'(o_wrap), 32'(e.wrap));
                check("sb_err",  32'(o_err),  32'(e.err));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] scan_exp [14] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h00,
                                      8'h20, 8'h20, 8'h20, 8'h20, 8'h00,
                                      8'h01, 8'h01, 8'h01, 8'h01};
        bit found;

        i_rst_n = 0; i_en = 1; i_mode = 0; i_opt = 0; i_load = 1; i_sel = 3'd2;
        cycle();
        cycle();
        check("reset_y", 32'(o_y), 32'hFF);
        check("reset_idx", 32'(o_idx), 32'd0);

        // Manual load with active-low polarity.
        i_rst_n = 1; i_load = 1; i_sel = 3'd3;
        cycle();
        check("load3_y", 32'(o_y), 32'hF7);
        check("load3_idx", 32'(o_idx), 32'd3);

        // Out-of-range load, then polarity flip.
        i_sel = 3'd7;
        cycle();
        check("bad_err", 32'(o_err), 32'd1);
        check("bad_y", 32'(o_y), 32'hF7);
        check("bad_idx", 32'(o_idx), 32'd3);
        i_load = 0; i_opt = 1;
        cycle();
        check("opt_err", 32'(o_err), 32'd0);
        check("opt_y", 32'(o_y), 32'h08);

        // Scan from idx 4 through the wrap.
        i_load = 1; i_sel = 3'd4;
        cycle();
        i_load = 0; i_en = 0;
        cycle();
        i_en = 1; i_mode = 1;
        for (int k = 0; k < 14; k++) begin
            cycle();
            check($sformatf("scan_y[%0d]", k), 32'(o_y), 32'(scan_exp[k]));
            check($sformatf("scan_wrap[%0d]", k), 32'(o_wrap), (k == 10) ? 32'd1 : 32'd0);
        end
        check("scan_wrap_idx", 32'(o_idx), 32'd0);

        // Drop enable mid-drive at idx 2, then re-enable for a full dwell.
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            cycle();
            if (o_idx == 3'd2 && o_y == 8'h04) found = 1;
        end
        check("reach_idx2", 32'(found), 32'd1);
        cycle();
        i_en = 0;
        cycle();
        check("en_off_y", 32'(o_y), 32'h00);
        check("en_off_idx", 32'(o_idx), 32'd2);
        i_en = 1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("redwell_y[%0d]", k), 32'(o_y), (k < 4) ? 32'h04 : 32'h00);
        end

        // Reset while blanking, with a load asserted.
        i_rst_n = 0; i_load = 1; i_sel = 3'd5;
        cycle();
        check("blank_rst_y", 32'(o_y), 32'hFF);
        check("blank_rst_idx", 32'(o_idx), 32'd0);
        check("blank_rst_wrap", 32'(o_wrap), 32'd0);
        check("blank_rst_err", 32'(o_err), 32'd0);
        i_rst_n = 1; i_load = 0;

        for (int k = 0; k < 3000; k++) begin
            i_rst_n = ($urandom_range(0, 199) != 0);
            i_en    = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 24) == 0) i_mode = ~i_mode;
            if ($urandom_range(0, 14) == 0) i_opt = ~i_opt;
            i_load  = ($urandom_range(0, 3) == 0);
            i_sel   = 3'($urandom_range(0, 7));
            cycle();
        end

        repeat (3) @(negedge i_clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_scan_nx.md
DECODER_SCAN_NX -- requirements
Module: decoder_scan_nx

Interface
REQ-001 SHALL have parameter SEL_W, default 3: select width; output width is 2**SEL_W.
REQ-002 SHALL have parameter NUM_CH, default 8: channels in use, 1..2**SEL_W.
REQ-003 SHALL have parameter DWELL, default 1000: scan-mode drive cycles per channel, >=1.
REQ-004 SHALL have parameter BLANK, default 2: scan-mode all-inactive cycles between channels, >=0.
REQ-005 SHALL have port i_clk, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port i_rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port i_en, input, 1: block enable.
REQ-008 SHALL have port i_mode, input, 1: 0 manual select, 1 auto scan.
REQ-009 SHALL have port i_opt, input, 1: polarity; 1 active-high one-hot, 0 active-low one-cold.
REQ-010 SHALL have port i_sel, input, SEL_W: manual channel index.
REQ-011 SHALL have port i_load, input, 1: manual-mode strobe that captures i_sel.
REQ-012 SHALL have port o_y, output, 2**SEL_W: registered decoded lines.
REQ-013 SHALL have port o_idx, output, SEL_W: registered current channel index.
REQ-014 SHALL have port o_wrap, output, 1: one-cycle pulse on scan wrap-around.
REQ-015 SHALL have port o_err, output, 1: one-cycle pulse on out-of-range manual load.

Function
REQ-016 SHALL implement states IDLE, DRIVE, BLANK; all outputs registered, 1-cycle latency from inputs to o_y.
REQ-017 Inactive pattern SHALL be all-zeros when i_opt=1, all-ones when i_opt=0; active pattern SHALL be the inactive pattern with bit o_idx inverted.
REQ-018 In IDLE, o_y SHALL be the inactive pattern for the current i_opt.
REQ-019 i_en=0 SHALL force IDLE on the next edge from any state; o_idx held; dwell/blank counter cleared.
REQ-020 Manual (i_en=1, i_mode=0): i_load=1 with i_sel<NUM_CH SHALL set o_idx=i_sel and enter DRIVE; o_y active on the following cycle.
REQ-021 Manual: DRIVE SHALL hold indefinitely until next valid load, i_en=0 or mode change; no blanking.
REQ-022 Manual: i_load=1 with i_sel>=NUM_CH SHALL pulse o_err for one cycle and leave state, o_idx and o_y unchanged.
REQ-023 Scan (i_en=1, i_mode=1): from IDLE SHALL enter DRIVE at current o_idx with counter cleared; i_load ignored.
REQ-024 Scan: DRIVE SHALL last exactly DWELL cycles, then BLANK for exactly BLANK cycles with o_y inactive; BLANK=0 skips BLANK.
REQ-025 Scan: on leaving BLANK (or DRIVE if BLANK=0), o_idx SHALL increment; at NUM_CH-1 it SHALL wrap to 0 and pulse o_wrap in the same cycle o_idx becomes 0.
REQ-026 Mode change 1->0 mid-scan SHALL go IDLE next edge, o_idx retained; 0->1 SHALL restart DRIVE at current o_idx with full DWELL.
REQ-027 i_opt change SHALL take effect on o_y at the next edge without disturbing state or counters.
REQ-028 Counter width SHALL be clog2 of max(DWELL,BLANK)+1; no overflow.

Reset
REQ-029 With i_rst_n=0 at an edge: state IDLE, o_idx=0, counter=0, o_wrap=0, o_err=0, o_y=all ones.
REQ-030 Reset SHALL override all other inputs including i_load; first non-reset edge follows REQ-018..026.

Structure
REQ-031 Package decoder_pkg SHALL hold the state enum and a polarity/one-hot decode function used by this and later decoder blocks.
REQ-032 Sub-module decoder_onehot (parametrised SEL_W, combinational, polarity input) SHALL be instantiated once to form the next o_y value.

Verification (SEL_W=3, NUM_CH=6, DWELL=4, BLANK=1)
REQ-033 Reset then i_en=1,i_mode=0,i_opt=0,i_load pulse i_sel=3 -> next cycle o_y=8'b1111_0111, o_idx=3.
REQ-034 Manual i_sel=7 load -> o_err pulses 1 cycle, o_y/o_idx unchanged; i_opt->1 -> o_y=8'b0000_1000 next edge.
REQ-035 Scan from o_idx=4, i_opt=1 -> 4 cycles o_y=8'h10, 1 cycle 8'h00, 4 cycles 8'h20, 1 cycle 8'h00, then o_idx=0 with o_wrap=1 and 4 cycles 8'h01.
REQ-036 Drop i_en mid-DRIVE at idx 2 -> o_y inactive next edge, o_idx=2; re-enable -> full 4-cycle DWELL on idx 2.
REQ-037 Assert i_rst_n=0 mid-BLANK -> next edge o_y=8'hFF, o_idx=0, o_wrap=0, o_err=0.
